// File: rtl/deskew_collector_16x8b.sv
// Re-aligns the diagonally skewed systolic-array result stream into full rows.
// Lane i arrives i cycles after lane 0, so lane i is delayed LANES-1-i cycles
// to line every lane up with the last one. Aligned rows go into a small
// first-word-fall-through FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk, reset_n    clock (rising edge) and asynchronous active-low reset
//   en              advances delay lines and valid chain; pushes only when high
//   flush           synchronous clear of valid chain, FIFO state, overflow, row_count
//   din_valid, din  skewed input row; lane i = din[DW*i +: DW]
//   m_valid, m_ready, m_data   aligned row output handshake
//   level           rows currently held in the FIFO
//   overflow        sticky: a row was dropped because the FIFO was full
//   row_count       rows popped since reset/flush, wraps at 2^16
module deskew_collector_16x8b #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         din_valid,
  input  logic [LANES*DW-1:0]          din,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*DW-1:0]          m_data,
  output logic [$clog2(OUT_DEPTH):0]   level,
  output logic                         overflow,
  output logic [15:0]                  row_count
);

  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned VW = LANES - 1;

  // ---------------------------------------------------------------------------
  // Deskew delay lines
  // ---------------------------------------------------------------------------
  logic [LANES*DW-1:0] aligned;

  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    localparam int Depth = LANES - 1 - i;
    logic [DW-1:0] sr_q [Depth];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < Depth; s++) sr_q[s] <= '0;
      end else if (en) begin
        sr_q[0] <= din[DW*i +: DW];
        for (int s = 1; s < Depth; s++) sr_q[s] <= sr_q[s-1];
      end
    end

    assign aligned[DW*i +: DW] = sr_q[Depth-1];
  end

  // The last lane is already aligned with the delayed earlier lanes.
  assign aligned[DW*(LANES-1) +: DW] = din[DW*(LANES-1) +: DW];

  // Valid chain tracks which cycle carries a complete row at the aligned tap.
  logic [VW-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (flush)   vld_d = '0;
    else if (en) vld_d = VW'({vld_q, din_valid});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [LANES*DW-1:0] mem_q [OUT_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         rc_q, rc_d;
  logic                full, empty, push, pop, accept;

  always_comb begin
    full     = (level_q == LW'(OUT_DEPTH));
    empty    = (level_q == '0);
    push     = en & vld_q[VW-1];
    pop      = ~empty & m_ready;
    // A pop in the same cycle frees the slot being written, so full is no barrier.
    accept   = push & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    rc_d     = rc_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      rc_d     = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rc_d     = rc_q + 16'd1;
      end
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push && full && !pop) ovf_d = 1'b1;
      if (accept && !pop)      level_d = level_q + LW'(1);
      else if (!accept && pop) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      rc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      rc_q     <= rc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < int'(OUT_DEPTH); d++) mem_q[d] <= '0;
    end else if (!flush && accept) begin
      mem_q[wr_ptr_q] <= aligned;
    end
  end

  assign m_valid   = ~empty;
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign row_count = rc_q;

endmodule

// File: doc/deskew_collector_16x8b.md
Name: deskew_collector_16x8b

Overview:
- Output-side counterpart of the input skew FIFOs: takes the diagonally skewed 16-lane x 8-bit result stream from the systolic array and re-aligns it into full 128-bit rows.
- Lane i arrives i cycles after lane 0.
- Aligned rows are buffered in a small first-word-fall-through FIFO and handed to the writeback path over a valid/ready handshake.

Parameters:
- LANES, 16, number of byte lanes (systolic array columns).
- DW, 8, bits per lane.
- OUT_DEPTH, 4, output FIFO depth in rows; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  advances the deskew pipeline; when low, delay lines and valid chain hold.
- flush  input  1  synchronous clear of the valid chain, FIFO pointers, level and overflow; data registers are not cleared.
- din_valid  input  1  lane-0 byte of a new skewed row is present this cycle (sampled only when en=1).
- din  input  LANES*DW  skewed input; lane i = din[DW*i +: DW].
- m_valid  output  1  an aligned row is available.
- m_ready  input  1  consumer accepts m_data this cycle.
- m_data  output  LANES*DW  aligned row; lane i = m_data[DW*i +: DW].
- level  output  clog2(OUT_DEPTH)+1  number of rows held in the FIFO.
- overflow  output  1  sticky; a row was dropped because the FIFO was full.
- row_count  output  16  rows popped since reset or flush; wraps modulo 2^16.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-row):
  - All delay registers, the valid chain, the FIFO storage and pointers, level, overflow and row_count go to 0.
  - m_valid=0 and m_data=0.
  - Partially collected rows are discarded.
- Deskew pipeline:
  - Lane i has a shift register of depth LANES-1-i; lane LANES-1 is taken directly from din.
  - din_valid feeds a valid shift register of depth LANES-1.
  - All of these shift only on clock edges with en=1.
- Aligned row:
  - Formed combinationally as {din lane LANES-1, lane LANES-2 delayed 1, ..., lane 0 delayed LANES-1}.
  - aligned_valid = output of the valid chain.
- Push condition: en=1 and aligned_valid=1.
- Latency: with en held high and the FIFO empty, din_valid in cycle t gives m_valid=1 and the aligned row on m_data in cycle t+LANES (t+16 by default).
- Back-to-back rows: din_valid high on consecutive cycles yields one push per cycle, in order.
- Pop condition: m_valid=1 and m_ready=1.
  - Pop is independent of en.
  - m_data advances to the next row on the following cycle, or m_valid drops if the FIFO is empty.
- Simultaneous push and pop:
  - Always legal, including when full or when empty with a push.
  - On simultaneous push and pop, level is unchanged.
  - When empty, a push and pop in the same cycle cannot occur, because m_valid is 0.
- Push while full without a pop:
  - The row is dropped and overflow is set to 1.
  - FIFO contents and level are unchanged.
  - overflow stays 1 until reset or flush.
- level ranges 0..OUT_DEPTH.
  - The read and write pointers wrap modulo OUT_DEPTH.
  - full = (level == OUT_DEPTH); empty = (level == 0).
- row_count increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
- flush = 1:
  - Next edge: valid chain = 0, pointers = 0, level = 0, m_valid = 0, overflow = 0, row_count = 0.
  - Flush has priority over a push and a pop in the same cycle.
  - Rows in flight are lost.
- en = 0:
  - No shift and no push, even if aligned_valid = 1.
  - din_valid is ignored.
  - The pipeline resumes exactly where it paused when en returns to 1.

Test Plan:
- Reset then a single row:
  - Stimulus: drive lane i = 8'h10+i at cycle t+i with din_valid at t, en=1, m_ready=1.
  - Required: m_valid in cycle t+16; m_data = 128'h1F1E1D1C1B1A19181716151413121110; level returns to 0; row_count=1.
- Four back-to-back rows, then stall:
  - Stimulus: rows k=0..3 with lane byte = 8'h(k*16+i); m_ready=0.
  - Required: level=4, m_valid=1, overflow=0.
  - Then m_ready=1 for 4 cycles: rows pop in order 0..3; row_count=4.
- Overflow:
  - Stimulus: five rows with m_ready=0.
  - Required: the fifth row is dropped, overflow=1, level=4, the first four rows pop intact.
  - Then flush: overflow=0, level=0, row_count=0.
- en pause:
  - Stimulus: one row with en dropped for 3 cycles at cycle t+5.
  - Required: m_valid in cycle t+19, data correctly aligned (same as scenario 1).
- Full with simultaneous push and pop:
  - Stimulus: level=4, m_ready=1 in the same cycle as a push.
  - Required: level stays 4, overflow=0, no data loss.
- Reset mid-row:
  - Stimulus: assert reset_n=0 at cycle t+7 of a row.
  - Required: after release, m_valid stays 0 for at least 20 cycles with no new din_valid; level=0.
